// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding and key-index constants for the calculator sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        CALC   = 3'd4,
        SHOW   = 3'd5
    } calc_state_t;

    localparam int KEY_COUNT = 5;
    localparam int KEY_ENTER = 0;
    localparam int KEY_ADD   = 1;
    localparam int KEY_SUB   = 2;
    localparam int KEY_EQ    = 3;
    localparam int KEY_CLEAR = 4;

endpackage

// File: rtl/calc_sequencer_key_edge.sv
// key_edge: vector rising-edge detector; history resets to all-ones so keys held through reset never fire.
module key_edge #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] keys,
    output logic [W-1:0] events
);

    logic [W-1:0] keys_q;

    always_ff @(posedge clk)
        keys_q <= rst ? '1 : keys;

    assign events = keys & ~keys_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven load/strobe sequencer for the calculator datapath.
// Optional CALC_CHAIN_EN: operator keys in SHOW chain the result back into A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] In,
    input  logic         Enter,
    input  logic         OpAdd,
    input  logic         OpSub,
    input  logic         Equals,
    input  logic         ClearKey,
    input  logic [N-1:0] ResultIn,
    input  logic         OvrIn,
    output logic [N-1:0] Data,
    output logic         LoadA,
    output logic         LoadB,
    output logic         LoadR,
    output logic         AddSub,
    output logic         ClearOut,
    output logic         ShowResult,
    output logic         OvrFlag,
    output logic [2:0]   State
);

    calc_state_t          state;
    logic [KEY_COUNT-1:0] ev;
    logic                 clr, eq, sub, add, ent, op;

    key_edge #(.W(KEY_COUNT)) u_key_edge (
        .clk   (Clock),
        .rst   (Reset),
        .keys  ({ClearKey, Equals, OpSub, OpAdd, Enter}),
        .events(ev)
    );

    // Strict priority: only the highest event survives, the rest are dropped.
    assign clr = ev[KEY_CLEAR];
    assign eq  = ev[KEY_EQ]    & ~clr;
    assign sub = ev[KEY_SUB]   & ~clr & ~eq;
    assign add = ev[KEY_ADD]   & ~clr & ~eq & ~sub;
    assign ent = ev[KEY_ENTER] & ~clr & ~eq & ~sub & ~add;
    assign op  = add | sub;

    assign State = state;

`ifndef CALC_CHAIN_EN
    logic unused_result;
    assign unused_result = ^ResultIn;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            Data       <= '0;
            LoadA      <= 1'b0;
            LoadB      <= 1'b0;
            LoadR      <= 1'b0;
            AddSub     <= 1'b0;
            ClearOut   <= 1'b1;
            ShowResult <= 1'b0;
            OvrFlag    <= 1'b0;
        end else begin
            Data     <= In;
            LoadA    <= 1'b0;
            LoadB    <= 1'b0;
            LoadR    <= 1'b0;
            ClearOut <= 1'b0;
            if (clr) begin
                ClearOut   <= 1'b1;
                OvrFlag    <= 1'b0;
                AddSub     <= 1'b0;
                ShowResult <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: if (ent) begin
                        LoadA <= 1'b1;
                        state <= GOT_A;
                    end
                    GOT_A: if (ent) LoadA <= 1'b1;
                    else if (op) begin
                        AddSub <= sub;
                        state  <= GOT_OP;
                    end
                    GOT_OP: if (op) AddSub <= sub;
                    else if (ent) begin
                        LoadB <= 1'b1;
                        state <= GOT_B;
                    end
                    GOT_B: if (eq) begin
                        LoadR <= 1'b1;
                        state <= CALC;
                    end else if (ent) LoadB <= 1'b1;
                    CALC: begin
                        OvrFlag    <= OvrIn;
                        ShowResult <= 1'b1;
                        state      <= SHOW;
                    end
                    SHOW: if (ent) begin
                        LoadA      <= 1'b1;
                        OvrFlag    <= 1'b0;
                        ShowResult <= 1'b0;
                        state      <= GOT_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (op) begin
                        LoadA      <= 1'b1;
                        Data       <= ResultIn;
                        AddSub     <= sub;
                        OvrFlag    <= 1'b0;
                        ShowResult <= 1'b0;
                        state      <= GOT_OP;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench with an 8-bit datapath model and a result scoreboard.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] In = 8'h00;
    logic       Enter = 1'b0, OpAdd = 1'b0, OpSub = 1'b0, Equals = 1'b0, ClearKey = 1'b0;
    logic [7:0] ResultIn;
    logic       OvrIn;
    logic [7:0] Data;
    logic       LoadA, LoadB, LoadR, AddSub, ClearOut, ShowResult, OvrFlag;
    logic [2:0] State;

    calc_sequencer #(.N(8)) dut (
        .Clock(Clock), .Reset(Reset), .In(In), .Enter(Enter), .OpAdd(OpAdd), .OpSub(OpSub),
        .Equals(Equals), .ClearKey(ClearKey), .ResultIn(ResultIn), .OvrIn(OvrIn), .Data(Data),
        .LoadA(LoadA), .LoadB(LoadB), .LoadR(LoadR), .AddSub(AddSub), .ClearOut(ClearOut),
        .ShowResult(ShowResult), .OvrFlag(OvrFlag), .State(State)
    );

    always #5 Clock = ~Clock;

    // Datapath model: registered A/B/R, combinational sum and signed overflow.
    logic [7:0] a_r, b_r, r_r, res;
    assign res      = AddSub ? a_r - b_r : a_r + b_r;
    assign OvrIn    = AddSub ? (a_r[7] != b_r[7] && res[7] != a_r[7]) : (a_r[7] == b_r[7] && res[7] != a_r[7]);
    assign ResultIn = r_r;

    always @(posedge Clock) begin
        if (ClearOut) begin
            a_r <= 8'h00; b_r <= 8'h00; r_r <= 8'h00;
        end else begin
            if (LoadA) a_r <= Data;
            if (LoadB) b_r <= Data;
            if (LoadR) r_r <= res;
        end
    end

    int checks = 0;
    int errors = 0;
    int cnt_a = 0, cnt_b = 0, cnt_r = 0, cnt_c = 0;
    logic [8:0] exp_q[$];
    logic       show_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        cnt_a += int'(LoadA);
        cnt_b += int'(LoadB);
        cnt_r += int'(LoadR);
        cnt_c += int'(ClearOut);
        check("strobe_exclusive", 32'($countones({LoadA, LoadB, LoadR, ClearOut}) <= 1), 32'd1);
        if (ShowResult && !show_q) begin
            if (exp_q.size() == 0) check("scoreboard_unexpected", 32'd1, 32'd0);
            else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("result_r", 32'(r_r), 32'(e[7:0]));
                check("result_ovf", 32'(OvrFlag), 32'(e[8]));
            end
        end
        show_q = ShowResult;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic press(input int k);
        case (k)
            KEY_ENTER: Enter = 1'b1;
            KEY_ADD:   OpAdd = 1'b1;
            KEY_SUB:   OpSub = 1'b1;
            KEY_EQ:    Equals = 1'b1;
            default:   ClearKey = 1'b1;
        endcase
        tick(3);
        {Enter, OpAdd, OpSub, Equals, ClearKey} = 5'b0;
        tick(2);
    endtask

    int sa, sb, sr;

    initial begin
        // Reset with Enter already held: must not fire once reset drops.
        Enter = 1'b1; In = 8'h55;
        tick(3);
        check("rst_clearout", 32'(ClearOut), 32'd1);
        check("rst_state", 32'(State), 32'd0);
        check("rst_data", 32'(Data), 32'd0);
        check("rst_strobes", 32'({LoadA, LoadB, LoadR}), 32'd0);
        check("rst_flags", 32'({AddSub, ShowResult, OvrFlag}), 32'd0);
        Reset = 1'b0;
        tick(1);
        check("post_rst_clearout", 32'(ClearOut), 32'd0);
        check("post_rst_data", 32'(Data), 32'h55);
        tick(3);
        check("held_at_reset_no_loada", 32'(cnt_a), 32'd0);
        Enter = 1'b0;
        tick(2);

        // 5 + 3
        In = 8'd5; press(KEY_ENTER);
        check("add_state_got_a", 32'(State), 32'(GOT_A));
        press(KEY_ADD);
        check("add_state_got_op", 32'(State), 32'(GOT_OP));
        check("add_addsub", 32'(AddSub), 32'd0);
        In = 8'd3; press(KEY_ENTER);
        check("add_state_got_b", 32'(State), 32'(GOT_B));
        exp_q.push_back({1'b0, 8'd8});
        Equals = 1'b1;
        tick(1);
        check("add_loadr_latency", 32'(LoadR), 32'd1);
        tick(1);
        check("add_loadr_width", 32'(LoadR), 32'd0);
        check("add_show", 32'(ShowResult), 32'd1);
        Equals = 1'b0;
        tick(2);
        check("add_state_show", 32'(State), 32'(SHOW));

`ifdef CALC_CHAIN_EN
        OpAdd = 1'b1;
        tick(1);
        check("chain_loada", 32'(LoadA), 32'd1);
        check("chain_data", 32'(Data), 32'd8);
        check("chain_state", 32'(State), 32'(GOT_OP));
        check("chain_show_off", 32'(ShowResult), 32'd0);
        OpAdd = 1'b0;
        tick(2);
        In = 8'd2; press(KEY_ENTER);
        exp_q.push_back({1'b0, 8'd10});
        press(KEY_EQ);
        check("chain_state_show", 32'(State), 32'(SHOW));
`else
        sa = cnt_a;
        press(KEY_ADD);
        check("nochain_no_loada", 32'(cnt_a - sa), 32'd0);
        check("nochain_state", 32'(State), 32'(SHOW));
`endif
        press(KEY_CLEAR);
        check("clear_state", 32'(State), 32'(IDLE));

        // 3 - 5
        In = 8'd3; press(KEY_ENTER);
        press(KEY_SUB);
        check("sub_addsub", 32'(AddSub), 32'd1);
        In = 8'd5; press(KEY_ENTER);
        exp_q.push_back({1'b0, 8'hFE});
        Equals = 1'b1;
        tick(1);
        check("sub_loadr", 32'(LoadR), 32'd1);
        check("sub_addsub_at_loadr", 32'(AddSub), 32'd1);
        tick(1);
        check("sub_addsub_at_show", 32'(AddSub), 32'd1);
        Equals = 1'b0;
        tick(2);
        press(KEY_CLEAR);
        check("clear_addsub", 32'(AddSub), 32'd0);

        // 100 + 100 overflows
        In = 8'd100; press(KEY_ENTER);
        press(KEY_ADD);
        press(KEY_ENTER);
        exp_q.push_back({1'b1, 8'hC8});
        press(KEY_EQ);
        check("ovf_flag", 32'(OvrFlag), 32'd1);
        In = 8'd7; Enter = 1'b1;
        tick(1);
        check("ovf_enter_loada", 32'(LoadA), 32'd1);
        check("ovf_enter_clears", 32'(OvrFlag), 32'd0);
        check("ovf_enter_state", 32'(State), 32'(GOT_A));
        Enter = 1'b0;
        tick(2);

        // Equals and Enter together in GOT_B
        press(KEY_ADD);
        In = 8'd1; press(KEY_ENTER);
        sb = cnt_b;
        exp_q.push_back({1'b0, 8'd8});
        Equals = 1'b1; Enter = 1'b1;
        tick(1);
        check("simul_loadr", 32'(LoadR), 32'd1);
        check("simul_no_loadb", 32'(LoadB), 32'd0);
        {Equals, Enter} = 2'b0;
        tick(2);
        check("simul_loadb_count", 32'(cnt_b - sb), 32'd0);

        // ClearKey with Enter
        ClearKey = 1'b1; Enter = 1'b1;
        tick(1);
        check("clr_combo_clearout", 32'(ClearOut), 32'd1);
        check("clr_combo_no_loada", 32'(LoadA), 32'd0);
        {ClearKey, Enter} = 2'b0;
        tick(1);
        check("clr_combo_state", 32'(State), 32'(IDLE));

        // Enter held 10 cycles
        sa = cnt_a;
        Enter = 1'b1;
        tick(10);
        Enter = 1'b0;
        tick(2);
        check("held_enter_one_loada", 32'(cnt_a - sa), 32'd1);
        check("held_enter_state", 32'(State), 32'(GOT_A));

        // Reset in GOT_OP
        press(KEY_ADD);
        check("pre_reset_state", 32'(State), 32'(GOT_OP));
        Reset = 1'b1;
        tick(2);
        check("mid_reset_clearout", 32'(ClearOut), 32'd1);
        Reset = 1'b0;
        sa = cnt_a; sb = cnt_b; sr = cnt_r;
        tick(1);
        check("after_reset_clearout", 32'(ClearOut), 32'd0);
        tick(5);
        check("after_reset_no_strobes", 32'((cnt_a - sa) + (cnt_b - sb) + (cnt_r - sr)), 32'd0);
        check("after_reset_state", 32'(State), 32'(IDLE));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
